// File: rtl/l0_loader.sv
// l0_loader: upstream feeder for the row-parallel L0 input buffer.
//
// A start command in IDLE captures base_addr, len and stream_en.
// LOAD then reads len consecutive row*bw-bit vectors from the activation SRAM
// and writes them into L0 in address order.
// L0 backpressure is absorbed by a one-entry skid register.
// When stream_en was set, STREAM pulses l0_rd for len cycles.
// FLUSH then waits row cycles so the last staggered row read completes.
// DONE raises done for one cycle before the block returns to IDLE.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   start        command pulse, only sampled in IDLE
//   base_addr    first SRAM address of the command
//   len          vector count; values above 64 saturate to 64
//   stream_en    1 = run the STREAM/FLUSH phases after the load
//   mem_rd_en    SRAM read request (data appears on mem_dout next cycle)
//   mem_addr     SRAM read address
//   mem_dout     SRAM read data
//   l0_ready     L0 can accept a write this cycle
//   l0_wr, l0_in L0 write strobe and data (l0_in is 0 when l0_wr is low)
//   l0_rd        L0 read strobe
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
module l0_loader #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11,
  parameter int len_w  = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [len_w-1:0]    len,
  input  logic                stream_en,
  output logic                mem_rd_en,
  output logic [addr_w-1:0]   mem_addr,
  input  logic [row*bw-1:0]   mem_dout,
  input  logic                l0_ready,
  output logic                l0_wr,
  output logic [row*bw-1:0]   l0_in,
  output logic                l0_rd,
  output logic                busy,
  output logic                done
);

  localparam int vec_w   = row * bw;
  localparam int max_len = 64;
  localparam int fl_w    = (row > 1) ? $clog2(row) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, FLUSH, DONE} state_t;

  state_t               state;
  logic [addr_w-1:0]    base_q;
  logic [len_w-1:0]     len_q;
  logic                 stream_q;
  logic [len_w-1:0]     issued;
  logic [len_w-1:0]     written;
  logic [len_w-1:0]     stream_cnt;
  logic [fl_w-1:0]      flush_cnt;
  logic                 rd_pending;
  logic                 skid_valid;
  logic [vec_w-1:0]     skid;

  logic                 in_load;
  logic                 issue;
  logic                 ret_wr;
  logic                 drain_wr;
  logic                 wr;
  logic [len_w-1:0]     written_nxt;
  logic                 load_fin;

  // Lengths beyond the L0 FIFO depth are clamped to the depth.
  function automatic logic [len_w-1:0] sat_len(input logic [len_w-1:0] l);
    if (l > len_w'(max_len))
      return len_w'(max_len);
    return l;
  endfunction

  // ---- read issue / return path (combinational, gated by reset so an abort
  //      takes effect in the reset cycle itself) ----
  always_comb begin
    in_load  = (state == LOAD) && !reset;
    // No read while the skid is occupied or L0 is stalled, so returning
    // data can always either be written or parked in the empty skid.
    issue    = in_load && l0_ready && !skid_valid && (issued < len_q);
    ret_wr   = in_load && rd_pending && l0_ready;
    drain_wr = in_load && skid_valid && l0_ready;
    wr       = ret_wr || drain_wr;

    mem_rd_en = issue;
    mem_addr  = issue ? (base_q + addr_w'(issued)) : '0;

    l0_wr = wr;
    if (drain_wr)
      l0_in = skid;
    else if (ret_wr)
      l0_in = mem_dout;
    else
      l0_in = '0;

    written_nxt = wr ? (written + 1'b1) : written;
    load_fin    = (written_nxt == len_q);

    l0_rd = (state == STREAM) && !reset;
    busy  = (state != IDLE) && !reset;
    done  = (state == DONE) && !reset;
  end

  // ---- control state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      issued     <= '0;
      written    <= '0;
      stream_cnt <= '0;
      flush_cnt  <= '0;
      rd_pending <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            len_q      <= sat_len(len);
            stream_q   <= stream_en;
            issued     <= '0;
            written    <= '0;
            rd_pending <= 1'b0;
            skid_valid <= 1'b0;
            // A zero-length command spends one cycle in LOAD with nothing
            // to issue, then exits straight to DONE.
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (issue)
            issued <= issued + 1'b1;
          rd_pending <= issue;
          if (rd_pending && !l0_ready)
            skid_valid <= 1'b1;
          else if (drain_wr)
            skid_valid <= 1'b0;
          written <= written_nxt;
          if (load_fin) begin
            stream_cnt <= '0;
            state      <= (stream_q && (len_q != '0)) ? STREAM : DONE;
          end
        end
        STREAM: begin
          if (stream_cnt == len_q - 1'b1) begin
            flush_cnt <= '0;
            state     <= FLUSH;
          end else begin
            stream_cnt <= stream_cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == fl_w'(row - 1))
            state <= DONE;
          else
            flush_cnt <= flush_cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- skid data register (no reset; qualified by skid_valid) ----
  always_ff @(posedge clk) begin
    if (in_load && rd_pending && !l0_ready)
      skid <= mem_dout;
  end

endmodule
